// File: rtl/sample_ntt_parser_if.sv
// rtl/sample_ntt_parser_if.sv - squeeze-string input and coefficient output bundle for sample_ntt_parser
interface sample_ntt_parser_if #(
    parameter int IN_BITS = 5376,
    parameter int COEF_W  = 12
);
    logic [IN_BITS-1:0] in_string;
    logic               in_valid;
    logic               in_ready;
    logic [COEF_W-1:0]  coef;
    logic [7:0]         coef_idx;
    logic               coef_valid;
    logic               coef_ready;
    logic               need_more;
    logic               done;

    modport master (
        output in_string, in_valid, coef_ready,
        input  in_ready, coef, coef_idx, coef_valid, need_more, done
    );

    modport slave (
        input  in_string, in_valid, coef_ready,
        output in_ready, coef, coef_idx, coef_valid, need_more, done
    );
endinterface

// File: rtl/sample_ntt_parser.sv
// rtl/sample_ntt_parser.sv - Kyber Parse/SampleNTT rejection sampler over squeezed strings
// Optional reject statistics port under SAMPLE_REJECT_STATS_EN.
module sample_ntt_parser #(
    parameter int Q       = 3329,
    parameter int N       = 256,
    parameter int IN_BITS = 5376,
    parameter int COEF_W  = 12
) (
    input  logic                clk,
    input  logic                rst,
    sample_ntt_parser_if.slave  bus
`ifdef SAMPLE_REJECT_STATS_EN
    ,
    output logic [9:0]          reject_cnt
`endif
);
    localparam int NTRIP  = IN_BITS / 24;
    localparam int TPTR_W = $clog2(NTRIP);
    localparam logic [COEF_W-1:0] Q_W = COEF_W'(Q);

    typedef enum logic [2:0] {
        S_IDLE, S_CAND1, S_CAND2, S_WAIT_MORE, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IN_BITS-1:0] str_q, str_d;
    logic [TPTR_W-1:0]  tptr_q, tptr_d;
    logic [8:0]         count_q, count_d;
    logic               need_more_q, need_more_d;

    logic [COEF_W-1:0]  cand;
    logic               in_cand;
    logic               accept;
    logic               hs;
    logic               step;
    logic               last_coef;

`ifdef SAMPLE_REJECT_STATS_EN
    logic [9:0]         rej_q, rej_d;
    assign reject_cnt = rej_q;
`endif

    always_comb begin
        // The current triplet always sits in the low 24 bits; the string shifts down per triplet.
        cand      = (state_q == S_CAND2) ? str_q[23:12] : str_q[11:0];
        in_cand   = (state_q == S_CAND1) || (state_q == S_CAND2);
        accept    = in_cand && (cand < Q_W);
        hs        = accept && bus.coef_ready;
        step      = in_cand && (!accept || bus.coef_ready);
        last_coef = (count_q == 9'(N - 1));

        bus.coef_valid = accept;
        bus.coef       = accept ? cand : '0;
        bus.coef_idx   = accept ? count_q[7:0] : 8'd0;
        bus.in_ready   = (state_q == S_IDLE) || (state_q == S_WAIT_MORE) || (state_q == S_DONE);
        bus.done       = (state_q == S_DONE);
        bus.need_more  = need_more_q;

        state_d     = state_q;
        str_d       = str_q;
        tptr_d      = tptr_q;
        count_d     = count_q;
        need_more_d = 1'b0;
`ifdef SAMPLE_REJECT_STATS_EN
        rej_d = rej_q;
        if (in_cand && !accept && (rej_q != 10'h3FF)) begin
            rej_d = rej_q + 10'd1;
        end
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.in_valid) begin
                    str_d   = bus.in_string;
                    tptr_d  = '0;
                    count_d = '0;
                    state_d = S_CAND1;
`ifdef SAMPLE_REJECT_STATS_EN
                    rej_d   = '0;
`endif
                end
            end
            S_WAIT_MORE: begin
                if (bus.in_valid) begin
                    str_d   = bus.in_string;
                    tptr_d  = '0;
                    state_d = S_CAND1;
                end
            end
            S_CAND1: begin
                if (step) begin
                    state_d = S_CAND2;
                    if (hs) begin
                        count_d = count_q + 9'd1;
                        if (last_coef) state_d = S_DONE;
                    end
                end
            end
            S_CAND2: begin
                if (step) begin
                    if (hs) count_d = count_q + 9'd1;
                    if (hs && last_coef) begin
                        state_d = S_DONE;
                    end else if (tptr_q == TPTR_W'(NTRIP - 1)) begin
                        need_more_d = 1'b1;
                        state_d     = S_WAIT_MORE;
                    end else begin
                        tptr_d  = tptr_q + 1'b1;
                        str_d   = str_q >> 24;
                        state_d = S_CAND1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            str_q       <= '0;
            tptr_q      <= '0;
            count_q     <= '0;
            need_more_q <= 1'b0;
`ifdef SAMPLE_REJECT_STATS_EN
            rej_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            str_q       <= str_d;
            tptr_q      <= tptr_d;
            count_q     <= count_d;
            need_more_q <= need_more_d;
`ifdef SAMPLE_REJECT_STATS_EN
            rej_q       <= rej_d;
`endif
        end
    end
endmodule

// File: tb/tb_sample_ntt_parser.sv
// tb/tb_sample_ntt_parser.sv - scoreboard bench for sample_ntt_parser against a byte-level Parse model
module tb_sample_ntt_parser;
    localparam int IN_BITS = 5376;
    localparam int NT      = IN_BITS / 24;
    localparam int Q       = 3329;
    localparam int N       = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_ntt_parser_if #(.IN_BITS(IN_BITS), .COEF_W(12)) bus ();
`ifdef SAMPLE_REJECT_STATS_EN
    logic [9:0] reject_cnt;
`endif

    sample_ntt_parser #(.Q(Q), .N(N), .IN_BITS(IN_BITS), .COEF_W(12)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SAMPLE_REJECT_STATS_EN
        ,
        .reject_cnt(reject_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_coef[$];
    int exp_idx[$];
    int m_count = 0;
    int m_rej = 0;
    bit m_need_more = 0;
    int nm_seen = 0;
    int rdy_mode = 0;
    int bp_cnt = 0;
    bit stall_prev = 0;
    int prev_coef, prev_idx;
    bit done_next = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference Parse: walk bytes three at a time, two 12-bit candidates each.
    task automatic model_feed(input logic [IN_BITS-1:0] s);
        logic [IN_BITS-1:0] v;
        int b0, b1, b2, d;
        v = s;
        for (int t = 0; t < NT && m_count < N; t++) begin
            b0 = int'(v[24*t +: 8]);
            b1 = int'(v[24*t+8 +: 8]);
            b2 = int'(v[24*t+16 +: 8]);
            for (int k = 0; k < 2 && m_count < N; k++) begin
                d = (k == 0) ? (b0 + 256 * (b1 % 16)) : ((b1 / 16) + 16 * b2);
                if (d < Q) begin
                    exp_coef.push_back(d);
                    exp_idx.push_back(m_count);
                    m_count++;
                end else begin
                    m_rej++;
                end
            end
        end
        m_need_more = (m_count < N);
    endtask

    function automatic logic [IN_BITS-1:0] rand_str();
        logic [IN_BITS-1:0] r;
        for (int i = 0; i < IN_BITS / 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        bus.coef_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bp_cnt++;
            case (rdy_mode)
                1:       bus.coef_ready = (((bp_cnt / 3) % 2) == 0);
                2:       bus.coef_ready = 1'($urandom_range(0, 1));
                default: bus.coef_ready = 1'b1;
            endcase
        end
    end

    initial begin
        int ec, ei;
        forever begin
            @(negedge clk);
            if (done_next) begin
                check("done_after_idx255", int'(bus.done), 1);
                done_next = 0;
            end
            if (stall_prev) begin
                check("stall_valid_held", int'(bus.coef_valid), 1);
                check("stall_coef_stable", int'(bus.coef), prev_coef);
                check("stall_idx_stable", int'(bus.coef_idx), prev_idx);
            end
            stall_prev = bus.coef_valid && !bus.coef_ready;
            prev_coef  = int'(bus.coef);
            prev_idx   = int'(bus.coef_idx);
            if (bus.need_more) nm_seen++;
            if (bus.coef_valid && bus.coef_ready) begin
                if (exp_coef.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_coef actual=%0d idx=%0d expected=none", bus.coef, bus.coef_idx);
                end else begin
                    ec = exp_coef.pop_front();
                    ei = exp_idx.pop_front();
                    check("coef", int'(bus.coef), ec);
                    check("coef_idx", int'(bus.coef_idx), ei);
                    if (ei == N - 1) done_next = 1;
                end
            end
        end
    end

    task automatic send_string(input logic [IN_BITS-1:0] s, input bit new_poly);
        int guard = 0;
        while (!bus.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("in_ready_timeout", int'(bus.in_ready), 1);
        if (new_poly) begin
            m_count = 0;
            m_rej   = 0;
        end
        model_feed(s);
        @(posedge clk);
        #1;
        bus.in_string = s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic check_rej(input string name);
`ifdef SAMPLE_REJECT_STATS_EN
        check(name, int'(reject_cnt), (m_rej > 1023) ? 1023 : m_rej);
`else
        if (name.len() == 0) $display("unused");
`endif
    endtask

    task automatic wait_event(output int cyc, output bit got_done, output bit got_nm);
        cyc = 0;
        got_done = 0;
        got_nm = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (bus.need_more) begin
                got_nm = 1;
                break;
            end
        end
        if (!got_done && !got_nm) check("event_timeout", 0, 1);
    endtask

    task automatic run_random_poly(input string tag);
        int cyc;
        bit gd, gn;
        send_string(rand_str(), 1);
        for (int k = 0; k < 8; k++) begin
            wait_event(cyc, gd, gn);
            check({tag, "_need_more_expected"}, int'(gn), int'(m_need_more));
            check_rej({tag, "_reject_cnt"});
            if (gn) send_string(rand_str(), 0);
            else break;
        end
        check({tag, "_done"}, int'(bus.done), 1);
        check({tag, "_drained"}, exp_coef.size(), 0);
    endtask

    initial begin
        int cyc, nm0, guard;
        bit gd, gn;
        logic [IN_BITS-1:0] s;

        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_string = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_coef_valid", int'(bus.coef_valid), 0);
        check("rst_coef", int'(bus.coef), 0);
        check("rst_coef_idx", int'(bus.coef_idx), 0);
        check("rst_need_more", int'(bus.need_more), 0);
        check("rst_done", int'(bus.done), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // All-zero string: one coefficient per cycle, done after idx 255.
        nm0 = nm_seen;
        send_string('0, 1);
        wait_event(cyc, gd, gn);
        check("zeros_cycles_to_done", cyc, 257);
        check("zeros_done", int'(gd), 1);
        check("zeros_no_need_more", nm_seen - nm0, 0);
        check("zeros_drained", exp_coef.size(), 0);
        check_rej("zeros_reject_cnt");

        // Q-1 / Q boundary in the first two triplets.
        s = '0;
        s[23:0]  = 24'hD00D00;
        s[47:24] = 24'h000D01;
        send_string(s, 1);
        wait_event(cyc, gd, gn);
        check("bound_done", int'(gd), 1);
        check("bound_drained", exp_coef.size(), 0);
        check_rej("bound_reject_cnt");

        // All-0xFF: every candidate rejected, then continue with zeros.
        nm0 = nm_seen;
        s = '1;
        send_string(s, 1);
        wait_event(cyc, gd, gn);
        check("ff_cycles_to_need_more", cyc, 2 * NT + 1);
        check("ff_need_more", int'(gn), 1);
        check("ff_in_ready", int'(bus.in_ready), 1);
        check_rej("ff_reject_cnt");
        repeat (3) @(negedge clk);
        check("ff_need_more_once", nm_seen - nm0, 1);
        check("ff_need_more_pulse_low", int'(bus.need_more), 0);
        check("ff_wait_in_ready", int'(bus.in_ready), 1);
        send_string('0, 0);
        wait_event(cyc, gd, gn);
        check("ff_then_zeros_cycles", cyc, 257);
        check("ff_then_zeros_done", int'(gd), 1);
        check("ff_then_zeros_drained", exp_coef.size(), 0);
        check_rej("ff_then_zeros_reject_cnt");

        rdy_mode = 1;
        run_random_poly("backpressure");
        rdy_mode = 2;
        run_random_poly("vector_a");
        run_random_poly("vector_b");

        // Reset mid-polynomial at coef_idx 100.
        rdy_mode = 0;
        send_string('0, 1);
        guard = 0;
        while (!(bus.coef_valid && bus.coef_idx == 8'd100) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("reach_idx100", int'(bus.coef_idx), 100);
        rst = 1'b0;
        #1;
        check("midrst_coef_valid", int'(bus.coef_valid), 0);
        check("midrst_coef", int'(bus.coef), 0);
        check("midrst_coef_idx", int'(bus.coef_idx), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_need_more", int'(bus.need_more), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        exp_coef.delete();
        exp_idx.delete();
        stall_prev = 0;
        done_next = 0;
        @(negedge clk);
        check("midrst_held_valid", int'(bus.coef_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_random_poly("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_ntt_parser.md
Name: sample_ntt_parser

Overview:
- Consumer of the SHAKE128 sponge squeeze output. Takes the 5376-bit (672-byte) string produced for one public-matrix entry A[i][j].
- Applies Kyber Parse / SampleNTT rejection sampling and streams 256 coefficients in [0, 3328] to the matrix store over a valid/ready interface.
- Sits between sponge_const and the NTT-domain matrix buffer.
- If the string runs out before 256 coefficients are accepted, it requests another squeeze block.

Parameters:
- Q, 3329, modulus; candidates >= Q are rejected.
- N, 256, coefficients per polynomial.
- IN_BITS, 5376, width of one squeezed string; must be a multiple of 24.
- COEF_W, 12, coefficient width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_string  in  IN_BITS  squeezed bytes; byte k = in_string[8k+7:8k], byte 0 at the LSB.
- in_valid  in  1  one-cycle pulse (sponge done); in_string is valid in this cycle.
- in_ready  out  1  high in IDLE and WAIT_MORE.
- coef  out  COEF_W  accepted coefficient.
- coef_idx  out  8  index 0..255 of coef.
- coef_valid  out  1  coef/coef_idx are valid.
- coef_ready  in  1  downstream accepts.
- need_more  out  1  one-cycle pulse: input exhausted, more squeeze data needed.
- done  out  1  high from the cycle after the 256th handshake until the next in_valid or reset.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters 0, coef=0, coef_idx=0, coef_valid=0, need_more=0, done=0, in_ready=1, internal string register cleared.
- Triplet t (0..IN_BITS/24-1) uses bytes b0,b1,b2 = bytes 3t, 3t+1, 3t+2.
  - d1 = b0 + 256*(b1 & 0xF).
  - d2 = (b1 >> 4) + 16*b2.
  - Both are 12-bit values; no arithmetic reduction is applied.
- States:
  - IDLE: on in_valid, latch in_string, clear triplet ptr and coef count, clear done, go to CAND1.
  - CAND1: evaluate d1 of the current triplet.
    - If d1 >= Q: coef_valid stays 0; go to CAND2 next cycle.
    - Otherwise drive coef=d1, coef_idx=count, coef_valid=1. Hold them stable until coef_valid & coef_ready. On the handshake, count++ and go to CAND2, or DONE if count reaches N.
  - CAND2: same as CAND1 using d2. Afterwards, advance the triplet ptr and go to CAND1. If the last triplet has been consumed and count < N, pulse need_more and go to WAIT_MORE.
  - WAIT_MORE: in_ready=1. On in_valid, latch the new string, reset the triplet ptr only (count is kept), go to CAND1.
  - DONE: done=1, in_ready=1. On in_valid, start a new polynomial as from IDLE.
- Rate: at most one candidate evaluated per cycle, at most one coefficient output per cycle.
- Latency from in_valid to the first possible coef_valid: 1 cycle.
- Boundary cases:
  - d1 = 3328 is accepted; d1 = 3329 is rejected.
  - Acceptance of the 256th coefficient ends parsing immediately. The remaining candidate and remaining triplets are discarded.
  - A coef_valid, once raised, is never dropped without a handshake.
  - in_valid in CAND1/CAND2 is ignored; the upstream must wait for in_ready.
  - Reset mid-operation aborts the polynomial and returns to IDLE with no further outputs.
- Fully synchronous except for the reset.

Optional Feature:
- Macro: SAMPLE_REJECT_STATS_EN.
- When defined, adds an output port reject_cnt (out, 10 bits):
  - Counts rejected candidates for the current polynomial.
  - Cleared on a new polynomial start and on reset.
  - Saturates at 1023.
  - Frozen in DONE.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- All bytes = 0x00, coef_ready=1:
  - 256 coefficients of value 0, idx 0..255, one per cycle.
  - done rises the cycle after idx 255; need_more never pulses.
- Triplet 0 = {0x00,0x0D,0xD0}, triplet 1 = {0x01,0x0D,0x00}, rest 0x00:
  - d1=3328 accepted, d2=3328 accepted, then 3329 rejected, then 0.
  - First outputs are 3328 (idx 0), 3328 (idx 1), 0 (idx 2).
- All bytes = 0xFF:
  - No coef_valid.
  - need_more pulses once after 448 evaluation cycles; WAIT_MORE with in_ready=1.
  - Then an all-0x00 string yields idx 0..255 = 0.
  - With SAMPLE_REJECT_STATS_EN, reject_cnt = 448.
- Backpressure: coef_ready toggled 0/1 every 3 cycles on a random string.
  - coef/coef_idx stay stable while stalled.
  - Output sequence matches the software Parse of the same bytes.
- Known vector from the sponge_const bench (seed f8f1…5598, 5376-bit output) fed as in_string:
  - 256 coefficients match the reference Kyber SampleNTT model.
- rst asserted at coef_idx 100:
  - All outputs are 0 in the same cycle.
  - A new in_valid restarts at idx 0 with the correct values.
